// File: rtl/conv33_pkg.sv
// conv33_pkg: shared types and defaults for the conv33 window path.
//   state_t        : window generator FSM states (IDLE, RUN, DRAIN)
//   DATA_WIDTH_DEF : default pixel width, also used by the conv33 input buffer
package conv33_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/conv33_line_buffer.sv
// conv33_line_buffer: one image row of pixel storage.
//   clk     : clock
//   we      : write enable
//   addr    : shared read/write column address
//   wr_data : pixel written at addr when we=1
//   rd_data : pixel stored at addr before this cycle's write (read-before-write)
// Contents are not reset; every entry is written in a frame before it is read.
module conv33_line_buffer
  import conv33_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_W      = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [IMG_W];

  // Asynchronous read of the old entry; the write lands at the clock edge.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv33_window_gen.sv
// conv33_window_gen: raster pixel stream to 3x3 windows (stride 1, no padding).
//   clk, rst           : clock, asynchronous active-high reset
//   start              : begins a frame (honoured only in IDLE)
//   pix_valid/ready    : input pixel handshake, pix_data in raster order
//   valid_out/ready_in : output window handshake
//   out_r_c            : window element, r=0 oldest row, c=0 leftmost column
//   busy               : frame in progress
// Optional macro CONV33_WINGEN_STATUS_EN adds:
//   frame_done         : one-cycle pulse after the final window handshake
//   win_count          : windows handshaken since the last start
module conv33_window_gen
  import conv33_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] out_0_0,
  output logic [DATA_WIDTH-1:0] out_0_1,
  output logic [DATA_WIDTH-1:0] out_0_2,
  output logic [DATA_WIDTH-1:0] out_1_0,
  output logic [DATA_WIDTH-1:0] out_1_1,
  output logic [DATA_WIDTH-1:0] out_1_2,
  output logic [DATA_WIDTH-1:0] out_2_0,
  output logic [DATA_WIDTH-1:0] out_2_1,
  output logic [DATA_WIDTH-1:0] out_2_2,
`ifdef CONV33_WINGEN_STATUS_EN
  output logic                  frame_done,
  output logic [$clog2((IMG_W-2)*(IMG_H-2)+1)-1:0] win_count,
`endif
  output logic                  busy
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] win [3][3];
  logic [DATA_WIDTH-1:0] lb0_q, lb1_q;
  logic                  accept, handshake, last_pix, qualify;

  assign pix_ready = (state == RUN) && !(valid_out && !ready_in);
  assign accept    = pix_valid && pix_ready;
  assign handshake = valid_out && ready_in;
  assign last_pix  = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  assign qualify   = (row >= RW'(2)) && (col >= CW'(2));
  assign busy      = (state != IDLE);

  conv33_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_W(IMG_W)) lb0 (
    .clk(clk), .we(accept), .addr(col), .wr_data(pix_data), .rd_data(lb0_q)
  );

  conv33_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_W(IMG_W)) lb1 (
    .clk(clk), .we(accept), .addr(col), .wr_data(lb0_q), .rd_data(lb1_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      valid_out <= 1'b0;
      win       <= '{default: '0};
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (accept && last_pix) state <= DRAIN;
        DRAIN:   if (handshake) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_q;
        win[1][2] <= lb0_q;
        win[2][2] <= pix_data;
        // Row counter is cleared explicitly at the end of the frame since
        // IMG_H need not be a power of two.
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        valid_out <= qualify;
      end else if (handshake) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef CONV33_WINGEN_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      win_count  <= '0;
    end else begin
      frame_done <= (state == DRAIN) && handshake;
      if (state == IDLE && start) win_count <= '0;
      else if (handshake)         win_count <= win_count + 1'b1;
    end
  end
`endif

  assign out_0_0 = win[0][0];
  assign out_0_1 = win[0][1];
  assign out_0_2 = win[0][2];
  assign out_1_0 = win[1][0];
  assign out_1_1 = win[1][1];
  assign out_1_2 = win[1][2];
  assign out_2_0 = win[2][0];
  assign out_2_1 = win[2][1];
  assign out_2_2 = win[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
module tb_conv33_window_gen;

  localparam int DW = 8;
  localparam int W0 = 4, H0 = 4, W1 = 5, H1 = 4;
  localparam int M_BASIC = 0, M_STALL = 1, M_START = 2, M_RESET = 3, M_RAND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst[2], start[2], pix_valid[2], pix_ready[2];
  logic          valid_out[2], ready_in[2], busy[2];
  logic [DW-1:0] pix_data[2];
  logic [DW-1:0] o[2][3][3];
`ifdef CONV33_WINGEN_STATUS_EN
  logic          frame_done[2];
  logic [2:0]    wc0, wc1;
`endif

  conv33_window_gen #(.DATA_WIDTH(DW), .IMG_W(W0), .IMG_H(H0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .pix_valid(pix_valid[0]),
    .pix_ready(pix_ready[0]), .pix_data(pix_data[0]), .valid_out(valid_out[0]),
    .ready_in(ready_in[0]),
    .out_0_0(o[0][0][0]), .out_0_1(o[0][0][1]), .out_0_2(o[0][0][2]),
    .out_1_0(o[0][1][0]), .out_1_1(o[0][1][1]), .out_1_2(o[0][1][2]),
    .out_2_0(o[0][2][0]), .out_2_1(o[0][2][1]), .out_2_2(o[0][2][2]),
`ifdef CONV33_WINGEN_STATUS_EN
    .frame_done(frame_done[0]), .win_count(wc0),
`endif
    .busy(busy[0])
  );

  conv33_window_gen #(.DATA_WIDTH(DW), .IMG_W(W1), .IMG_H(H1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .pix_valid(pix_valid[1]),
    .pix_ready(pix_ready[1]), .pix_data(pix_data[1]), .valid_out(valid_out[1]),
    .ready_in(ready_in[1]),
    .out_0_0(o[1][0][0]), .out_0_1(o[1][0][1]), .out_0_2(o[1][0][2]),
    .out_1_0(o[1][1][0]), .out_1_1(o[1][1][1]), .out_1_2(o[1][1][2]),
    .out_2_0(o[1][2][0]), .out_2_1(o[1][2][1]), .out_2_2(o[1][2][2]),
`ifdef CONV33_WINGEN_STATUS_EN
    .frame_done(frame_done[1]), .win_count(wc1),
`endif
    .busy(busy[1])
  );

  int chk_cnt = 0, pass_cnt = 0;
  int hs[2] = '{0, 0};
  int fd[2] = '{0, 0};
  logic [71:0] q0[$], q1[$];
  logic [DW-1:0] img[2][32];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int hgt(input int k);
    return (k == 0) ? H0 : H1;
  endfunction

  function automatic logic [71:0] win_of(input int k);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w = {w[63:0], o[k][r][c]};
    return w;
  endfunction

  // Reference: window anchored at bottom-right pixel (r,c) is img rows r-2..r, cols c-2..c.
  function automatic logic [71:0] ref_win(input int k, input int r, input int c);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w = {w[63:0], img[k][(r-2+i)*wid(k) + (c-2+j)]};
    return w;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Scoreboard monitor: every window handshake pops one expected window.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst[k] && valid_out[k] && ready_in[k]) begin
        hs[k]++;
        if (qsize(k) == 0) check("extra_window", 72'd1, 72'd0);
        else if (k == 0) check("window_k0", win_of(0), q0.pop_front());
        else check("window_k1", win_of(1), q1.pop_front());
      end
`ifdef CONV33_WINGEN_STATUS_EN
      if (frame_done[k]) fd[k]++;
`endif
    end
  end

  task automatic run_frame(input int k, input int mode);
    int W = wid(k), H = hgt(k), n = W * H;
    int idx = 0, cyc = 0, stall_left = 0, hs0, fd0;
    bit stalled = 0, chk_lat = 0, acc;
    logic [71:0] fw;
    for (int i = 0; i < n; i++) img[k][i] = (mode == M_RAND) ? DW'($urandom_range(0, 255)) : DW'(i);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        if (k == 0) q0.push_back(ref_win(k, r, c)); else q1.push_back(ref_win(k, r, c));
    fw = ref_win(k, 2, 2);
    hs0 = hs[k];
    fd0 = fd[k];
    @(posedge clk); #1;
    start[k] = 1'b1; ready_in[k] = 1'b1; pix_valid[k] = 1'b0;
    @(posedge clk); #1;
    start[k] = 1'b0;
    check("busy_after_start", 72'(busy[k]), 72'd1);
`ifdef CONV33_WINGEN_STATUS_EN
    if (k == 0) check("win_count_cleared", 72'(wc0), 72'd0);
`endif
    while (idx < n && cyc < 500) begin
      pix_valid[k] = (mode == M_RAND) ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_data[k]  = img[k][idx];
      if (mode == M_STALL && !stalled && valid_out[k]) begin
        stalled = 1; stall_left = 3;
      end
      if (stall_left > 0) ready_in[k] = 1'b0;
      else ready_in[k] = (mode == M_RAND) ? ($urandom_range(0, 1) == 1) : 1'b1;
      start[k] = (mode == M_START && idx == 6);
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_pix_ready", 72'(pix_ready[k]), 72'd0);
        check("stall_valid_hold", 72'(valid_out[k]), 72'd1);
        check("stall_window_hold", win_of(k), fw);
        stall_left--;
      end
      if (chk_lat) begin
        check("first_window_latency", 72'(valid_out[k]), 72'd1);
        chk_lat = 0;
      end
      acc = pix_valid[k] && pix_ready[k];
      if (acc && idx == 2 * W + 2 && mode != M_RAND) begin
        check("no_window_before_first", 72'(valid_out[k]), 72'd0);
        chk_lat = 1;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      if (mode == M_RESET && idx == 10) begin
        rst[k] = 1'b1; pix_valid[k] = 1'b0;
        #1;
        check("reset_window_zero", win_of(k), 72'd0);
        check("reset_valid_out", 72'(valid_out[k]), 72'd0);
        check("reset_pix_ready", 72'(pix_ready[k]), 72'd0);
        check("reset_busy", 72'(busy[k]), 72'd0);
        if (k == 0) q0.delete(); else q1.delete();
        @(posedge clk); #1;
        rst[k] = 1'b0;
        return;
      end
    end
    start[k] = 1'b0; pix_valid[k] = 1'b0;
    if (idx < n) check("pixel_timeout", 72'(idx), 72'(n));
    cyc = 0;
    while (busy[k] && cyc < 100) begin
      ready_in[k] = (mode == M_RAND) ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    ready_in[k] = 1'b1;
    check("busy_after_frame", 72'(busy[k]), 72'd0);
    check("windows_outstanding", 72'(qsize(k)), 72'd0);
    check("window_total", 72'(hs[k] - hs0), 72'((W - 2) * (H - 2)));
`ifdef CONV33_WINGEN_STATUS_EN
    @(negedge clk);
    check("frame_done_pulses", 72'(fd[k] - fd0), 72'd1);
    if (k == 0) check("win_count_final", 72'(wc0), 72'((W - 2) * (H - 2)));
    else check("win_count_final", 72'(wc1), 72'((W - 2) * (H - 2)));
`endif
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; pix_valid[k] = 1'b0;
      ready_in[k] = 1'b1; pix_data[k] = '0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_window", win_of(k), 72'd0);
      check("rst_valid_out", 72'(valid_out[k]), 72'd0);
      check("rst_pix_ready", 72'(pix_ready[k]), 72'd0);
      check("rst_busy", 72'(busy[k]), 72'd0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    pix_valid[0] = 1'b1;
    pix_data[0]  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("idle_pix_ready", 72'(pix_ready[0]), 72'd0);
      @(posedge clk); #1;
    end
    pix_valid[0] = 1'b0;

    run_frame(0, M_BASIC);
    run_frame(0, M_STALL);
    run_frame(0, M_START);
    run_frame(0, M_RESET);
    run_frame(0, M_BASIC);
    run_frame(0, M_RAND);
    repeat (3) run_frame(1, M_RAND);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
